// File: rtl/tl_ul_sram_responder_if.sv
// TileLink-UL channel A/D bundle between one master and one responder.
// Ports: none. Members are the A-channel request fields with a_ready, and the
// D-channel response fields with d_ready.
// Modports: master drives A and d_ready; slave drives D and a_ready.
interface tl_ul_sram_responder_if #(
  parameter int SOURCE_W = 4
);
  logic                a_valid;
  logic                a_ready;
  logic [2:0]          a_opcode;
  logic [2:0]          a_param;
  logic [2:0]          a_size;
  logic [SOURCE_W-1:0] a_source;
  logic [31:0]         a_address;
  logic [3:0]          a_mask;
  logic [31:0]         a_data;

  logic                d_valid;
  logic                d_ready;
  logic [2:0]          d_opcode;
  logic [1:0]          d_param;
  logic [2:0]          d_size;
  logic [SOURCE_W-1:0] d_source;
  logic                d_sink;
  logic                d_denied;
  logic [31:0]         d_data;
  logic                d_corrupt;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data,
           d_corrupt
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data,
           d_corrupt
  );
endinterface

// File: rtl/tl_ul_sram_responder.sv
// TileLink-UL single-beat responder backed by a DEPTH x 32-bit register file.
// Ports:
//   clk_i  - rising-edge clock
//   rst_ni - asynchronous active-low reset (empties queue, zeroes memory)
//   tl     - slave side of the A/D channel bundle
// Requests are decoded when A fires; the response is pushed into a 2-entry
// FIFO whose head drives channel D, so D fields hold while stalled.
module tl_ul_sram_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 16,
  parameter int          SOURCE_W  = 4
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  tl_ul_sram_responder_if.slave tl
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] D_ACK       = 3'd0;
  localparam logic [2:0] D_ACK_DATA  = 3'd1;

  typedef struct packed {
    logic [2:0]          opcode;
    logic [2:0]          size;
    logic [SOURCE_W-1:0] source;
    logic                denied;
    logic [31:0]         data;
  } rsp_t;

  logic [31:0] mem_q [DEPTH];
  rsp_t        fifo_q [2];
  logic [1:0]  count_q, count_d;
  logic        wr_ptr_q, rd_ptr_q;
  // Holds a_ready low until the first clock edge after reset release.
  logic        live_q;

  logic [32:0]      addr_ext_s, base_ext_s, limit_ext_s;
  logic [31:0]      offset_s;
  logic [IDX_W-1:0] idx_s;
  logic             in_range_s, op_ok_s, is_get_s, legal_s;
  logic             a_fire_s, d_fire_s;
  rsp_t             rsp_new_s, head_s;

  // Request decode: range check in 33 bits so BASE+DEPTH*4 cannot wrap.
  always_comb begin
    addr_ext_s  = {1'b0, tl.a_address};
    base_ext_s  = {1'b0, BASE_ADDR};
    limit_ext_s = base_ext_s + 33'(DEPTH * 4);
    in_range_s  = (addr_ext_s >= base_ext_s) && (addr_ext_s < limit_ext_s);
    offset_s    = tl.a_address - BASE_ADDR;
    idx_s       = offset_s[IDX_W+1:2];
    case (tl.a_opcode)
      OP_PUT_FULL, OP_PUT_PART, OP_GET: op_ok_s = 1'b1;
      default:                          op_ok_s = 1'b0;
    endcase
    is_get_s = (tl.a_opcode == OP_GET);
    legal_s  = in_range_s && (tl.a_size <= 3'd2) && op_ok_s;

    rsp_new_s.opcode = is_get_s ? D_ACK_DATA : D_ACK;
    rsp_new_s.size   = tl.a_size;
    rsp_new_s.source = tl.a_source;
    rsp_new_s.denied = !legal_s;
    if (is_get_s && legal_s) begin
      rsp_new_s.data = mem_q[idx_s];
    end else begin
      rsp_new_s.data = 32'h0000_0000;
    end
  end

  // The d_ready -> a_ready path lets a full queue accept while its head drains.
  assign tl.a_ready = live_q && ((count_q < 2'd2) || ((count_q == 2'd2) && tl.d_ready));
  assign a_fire_s   = tl.a_valid && tl.a_ready;
  assign d_fire_s   = tl.d_valid && tl.d_ready;
  assign count_d    = count_q + {1'b0, a_fire_s} - {1'b0, d_fire_s};

  // Response FIFO state: pointers toggle (mod 2), count tracks occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      live_q   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      live_q  <= 1'b1;
      count_q <= count_d;
      if (a_fire_s) begin
        fifo_q[wr_ptr_q] <= rsp_new_s;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (d_fire_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // Memory: byte-masked write for legal Puts at the A fire edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else if (a_fire_s && legal_s && !is_get_s) begin
      for (int b = 0; b < 4; b++) begin
        if (tl.a_mask[b]) begin
          mem_q[idx_s][8*b +: 8] <= tl.a_data[8*b +: 8];
        end
      end
    end
  end

  // D channel: head entry, forced to zero whenever no response is pending.
  assign head_s       = fifo_q[rd_ptr_q];
  assign tl.d_valid   = (count_q != 2'd0);
  assign tl.d_opcode  = tl.d_valid ? head_s.opcode : 3'd0;
  assign tl.d_size    = tl.d_valid ? head_s.size : 3'd0;
  assign tl.d_source  = tl.d_valid ? head_s.source : {SOURCE_W{1'b0}};
  assign tl.d_denied  = tl.d_valid && head_s.denied;
  assign tl.d_data    = tl.d_valid ? head_s.data : 32'h0000_0000;
  assign tl.d_corrupt = tl.d_valid && head_s.denied && (head_s.opcode == D_ACK_DATA);
  assign tl.d_param   = 2'd0;
  assign tl.d_sink    = 1'b0;

  // a_param is ignored; untouched offset bits are alignment/out-of-range bits.
  logic unused_s;
  assign unused_s = ^{tl.a_param, offset_s};

endmodule

// File: tb/tb_tl_ul_sram_responder.sv
module tb_tl_ul_sram_responder;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          DEPTH = 16;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  tl_ul_sram_responder_if #(.SOURCE_W(4)) bus ();

  tl_ul_sram_responder #(
    .BASE_ADDR(BASE),
    .DEPTH    (DEPTH),
    .SOURCE_W (4)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .tl    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one A request at a negedge and wait (bounded) for it to fire.
  // Returns 1 time unit after the firing edge with a_valid dropped.
  task automatic do_req(input logic [2:0] op, input logic [2:0] sz, input logic [31:0] addr,
                        input logic [3:0] mask, input logic [31:0] data, input logic [3:0] src);
    logic fired;
    @(negedge clk);
    bus.a_opcode  = op;
    bus.a_param   = 3'd0;
    bus.a_size    = sz;
    bus.a_address = addr;
    bus.a_mask    = mask;
    bus.a_data    = data;
    bus.a_source  = src;
    bus.a_valid   = 1'b1;
    fired = 1'b0;
    for (int i = 0; i < 20 && !fired; i++) begin
      if (bus.a_ready) begin
        @(posedge clk);
        fired = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!fired) begin
      n_cmp++; n_err++;
      $display("FAIL a_fire_timeout: got no accept, required accept within 20 cycles");
    end
    #1 bus.a_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.a_valid = 1'b0; bus.d_ready = 1'b1;
    bus.a_opcode = 3'd0; bus.a_param = 3'd0; bus.a_size = 3'd0; bus.a_source = 4'd0;
    bus.a_address = 32'd0; bus.a_mask = 4'd0; bus.a_data = 32'd0;
    #3;
    n_cmp++; if (bus.d_valid !== 1'b0) begin n_err++; $display("FAIL rst_d_valid: got %b required 0", bus.d_valid); end
    n_cmp++; if (bus.a_ready !== 1'b0) begin n_err++; $display("FAIL rst_a_ready: got %b required 0", bus.a_ready); end
    n_cmp++; if (bus.d_data !== 32'd0) begin n_err++; $display("FAIL rst_d_data: got %h required 0", bus.d_data); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.a_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_a_ready: got %b required 1", bus.a_ready); end
    n_cmp++; if (bus.d_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_d_valid: got %b required 0", bus.d_valid); end
  endtask

  task automatic test_put_get();
    do_req(3'd0, 3'd2, BASE + 32'd4, 4'hF, 32'hDEADBEEF, 4'd3);
    n_cmp++; if (bus.d_valid !== 1'b1) begin n_err++; $display("FAIL put_d_valid: got %b required 1", bus.d_valid); end
    n_cmp++; if (bus.d_opcode !== 3'd0) begin n_err++; $display("FAIL put_opcode: got %0d required 0", bus.d_opcode); end
    n_cmp++; if (bus.d_source !== 4'd3) begin n_err++; $display("FAIL put_source: got %0d required 3", bus.d_source); end
    n_cmp++; if (bus.d_denied !== 1'b0) begin n_err++; $display("FAIL put_denied: got %b required 0", bus.d_denied); end
    do_req(3'd4, 3'd2, BASE + 32'd4, 4'hF, 32'd0, 4'd5);
    n_cmp++; if (bus.d_opcode !== 3'd1) begin n_err++; $display("FAIL get_opcode: got %0d required 1", bus.d_opcode); end
    n_cmp++; if (bus.d_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL get_data: got %h required deadbeef", bus.d_data); end
    n_cmp++; if (bus.d_source !== 4'd5) begin n_err++; $display("FAIL get_source: got %0d required 5", bus.d_source); end
    n_cmp++; if (bus.d_size !== 3'd2) begin n_err++; $display("FAIL get_size: got %0d required 2", bus.d_size); end
    n_cmp++; if ({bus.d_denied, bus.d_corrupt} !== 2'b00) begin n_err++; $display("FAIL get_den_cor: got %b required 00", {bus.d_denied, bus.d_corrupt}); end
  endtask

  task automatic test_partial();
    do_req(3'd1, 3'd2, BASE + 32'd4, 4'b0101, 32'h11223344, 4'd6);
    n_cmp++; if ({bus.d_opcode, bus.d_denied} !== 4'b0000) begin n_err++; $display("FAIL partial_ack: got op=%0d den=%b required op=0 den=0", bus.d_opcode, bus.d_denied); end
    do_req(3'd4, 3'd2, BASE + 32'd4, 4'hF, 32'd0, 4'd7);
    n_cmp++; if (bus.d_data !== 32'hDE22BE44) begin n_err++; $display("FAIL partial_data: got %h required de22be44", bus.d_data); end
  endtask

  task automatic test_illegal();
    do_req(3'd4, 3'd2, BASE + 32'(DEPTH * 4), 4'hF, 32'd0, 4'd7);
    n_cmp++; if (bus.d_opcode !== 3'd1) begin n_err++; $display("FAIL oor_get_opcode: got %0d required 1", bus.d_opcode); end
    n_cmp++; if ({bus.d_denied, bus.d_corrupt} !== 2'b11) begin n_err++; $display("FAIL oor_get_den_cor: got %b required 11", {bus.d_denied, bus.d_corrupt}); end
    n_cmp++; if (bus.d_data !== 32'd0) begin n_err++; $display("FAIL oor_get_data: got %h required 0", bus.d_data); end
    do_req(3'd4, 3'd2, BASE - 32'd4, 4'hF, 32'd0, 4'd8);
    n_cmp++; if (bus.d_denied !== 1'b1) begin n_err++; $display("FAIL below_base_denied: got %b required 1", bus.d_denied); end
    do_req(3'd2, 3'd2, BASE + 32'd4, 4'hF, 32'hFFFFFFFF, 4'd9);
    n_cmp++; if ({bus.d_opcode, bus.d_denied, bus.d_corrupt} !== 5'b00010) begin n_err++; $display("FAIL arith_rsp: got op=%0d den=%b cor=%b required op=0 den=1 cor=0", bus.d_opcode, bus.d_denied, bus.d_corrupt); end
    do_req(3'd0, 3'd3, BASE + 32'd4, 4'hF, 32'hFFFFFFFF, 4'd10);
    n_cmp++; if (bus.d_denied !== 1'b1) begin n_err++; $display("FAIL size3_denied: got %b required 1", bus.d_denied); end
    do_req(3'd4, 3'd2, BASE + 32'd4, 4'hF, 32'd0, 4'd11);
    n_cmp++; if (bus.d_data !== 32'hDE22BE44) begin n_err++; $display("FAIL illegal_no_write: got %h required de22be44", bus.d_data); end
    do_req(3'd0, 3'd2, BASE + 32'd60, 4'hF, 32'h600DF00D, 4'd12);
    n_cmp++; if (bus.d_denied !== 1'b0) begin n_err++; $display("FAIL last_word_put: got den=%b required 0", bus.d_denied); end
    do_req(3'd4, 3'd2, BASE + 32'd60, 4'hF, 32'd0, 4'd13);
    n_cmp++; if (bus.d_data !== 32'h600DF00D) begin n_err++; $display("FAIL last_word_get: got %h required 600df00d", bus.d_data); end
  endtask

  task automatic test_put_then_get();
    @(negedge clk);
    bus.a_opcode = 3'd0; bus.a_size = 3'd2; bus.a_address = BASE + 32'd16;
    bus.a_mask = 4'hF; bus.a_data = 32'h13579BDF; bus.a_source = 4'd8; bus.a_valid = 1'b1;
    @(posedge clk); #1;
    bus.a_opcode = 3'd4; bus.a_source = 4'd9; bus.a_data = 32'd0;
    n_cmp++; if ({bus.d_valid, bus.d_source} !== 5'b1_1000) begin n_err++; $display("FAIL p2g_put_rsp: got v=%b src=%0d required v=1 src=8", bus.d_valid, bus.d_source); end
    n_cmp++; if (bus.a_ready !== 1'b1) begin n_err++; $display("FAIL p2g_a_ready: got %b required 1", bus.a_ready); end
    @(posedge clk); #1;
    bus.a_valid = 1'b0;
    n_cmp++; if (bus.d_source !== 4'd9) begin n_err++; $display("FAIL p2g_get_source: got %0d required 9", bus.d_source); end
    n_cmp++; if (bus.d_data !== 32'h13579BDF) begin n_err++; $display("FAIL p2g_get_data: got %h required 13579bdf", bus.d_data); end
    @(posedge clk); #1;
    n_cmp++; if (bus.d_valid !== 1'b0) begin n_err++; $display("FAIL p2g_drained: got %b required 0", bus.d_valid); end
  endtask

  task automatic test_back_to_back();
    do_req(3'd0, 3'd2, BASE + 32'd8, 4'hF, 32'hA5A50008, 4'd0);
    do_req(3'd0, 3'd2, BASE + 32'd12, 4'hF, 32'h0000C00C, 4'd0);
    @(posedge clk); #1;
    bus.d_ready = 1'b0;
    @(negedge clk);
    bus.a_opcode = 3'd4; bus.a_size = 3'd2; bus.a_mask = 4'hF; bus.a_data = 32'd0;
    bus.a_address = BASE + 32'd4; bus.a_source = 4'd1; bus.a_valid = 1'b1;
    @(posedge clk); #1;
    bus.a_address = BASE + 32'd8; bus.a_source = 4'd2;
    @(posedge clk); #1;
    bus.a_address = BASE + 32'd12; bus.a_source = 4'd3;
    n_cmp++; if (bus.a_ready !== 1'b0) begin n_err++; $display("FAIL full_a_ready: got %b required 0", bus.a_ready); end
    n_cmp++; if ({bus.d_valid, bus.d_source} !== 5'b1_0001) begin n_err++; $display("FAIL full_head: got v=%b src=%0d required v=1 src=1", bus.d_valid, bus.d_source); end
    n_cmp++; if (bus.d_data !== 32'hDE22BE44) begin n_err++; $display("FAIL full_head_data: got %h required de22be44", bus.d_data); end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({bus.d_source, bus.d_opcode} !== 7'b0001_001) begin n_err++; $display("FAIL stall_stable: got src=%0d op=%0d required src=1 op=1", bus.d_source, bus.d_opcode); end
    n_cmp++; if (bus.d_data !== 32'hDE22BE44) begin n_err++; $display("FAIL stall_data: got %h required de22be44", bus.d_data); end
    n_cmp++; if (bus.a_ready !== 1'b0) begin n_err++; $display("FAIL stall_a_ready: got %b required 0", bus.a_ready); end
    @(negedge clk);
    bus.d_ready = 1'b1;
    #1;
    n_cmp++; if (bus.a_ready !== 1'b1) begin n_err++; $display("FAIL drain_a_ready: got %b required 1", bus.a_ready); end
    @(posedge clk); #1;
    bus.a_valid = 1'b0;
    n_cmp++; if (bus.d_source !== 4'd2) begin n_err++; $display("FAIL drain_src2: got %0d required 2", bus.d_source); end
    n_cmp++; if (bus.d_data !== 32'hA5A50008) begin n_err++; $display("FAIL drain_data2: got %h required a5a50008", bus.d_data); end
    @(posedge clk); #1;
    n_cmp++; if (bus.d_source !== 4'd3) begin n_err++; $display("FAIL drain_src3: got %0d required 3", bus.d_source); end
    n_cmp++; if (bus.d_data !== 32'h0000C00C) begin n_err++; $display("FAIL drain_data3: got %h required 0000c00c", bus.d_data); end
    @(posedge clk); #1;
    n_cmp++; if (bus.d_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty: got %b required 0", bus.d_valid); end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    bus.d_ready = 1'b0;
    do_req(3'd4, 3'd2, BASE + 32'd4, 4'hF, 32'd0, 4'd1);
    do_req(3'd4, 3'd2, BASE + 32'd8, 4'hF, 32'd0, 4'd2);
    n_cmp++; if ({bus.d_valid, bus.a_ready} !== 2'b10) begin n_err++; $display("FAIL pre_rst_state: got v=%b rdy=%b required v=1 rdy=0", bus.d_valid, bus.a_ready); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.d_valid !== 1'b0) begin n_err++; $display("FAIL async_rst_d_valid: got %b required 0", bus.d_valid); end
    n_cmp++; if (bus.a_ready !== 1'b0) begin n_err++; $display("FAIL async_rst_a_ready: got %b required 0", bus.a_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.d_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.d_valid !== 1'b0) begin n_err++; $display("FAIL stale_d_beat: got %b required 0 (cycle %0d)", bus.d_valid, i); end
    end
    do_req(3'd4, 3'd2, BASE + 32'd4, 4'hF, 32'd0, 4'd4);
    n_cmp++; if (bus.d_data !== 32'd0) begin n_err++; $display("FAIL mem_cleared_w1: got %h required 0", bus.d_data); end
    do_req(3'd4, 3'd2, BASE + 32'd60, 4'hF, 32'd0, 4'd5);
    n_cmp++; if (bus.d_data !== 32'd0) begin n_err++; $display("FAIL mem_cleared_w15: got %h required 0", bus.d_data); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_put_get();
    test_partial();
    test_illegal();
    test_put_then_get();
    test_back_to_back();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
